// File: rtl/mulmod4591.sv
// Pipelined modular multiplier over Z/4591: out = (in_a * in_b) mod 4591.
// Three register stages (operands, product, Barrett-reduced result) gated by en.
module mulmod4591 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        in_valid,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        err
);

  localparam int unsigned Q         = 4591;
  localparam int unsigned W         = 16;
  localparam int unsigned BARRETT_K = 26;
  localparam int unsigned BARRETT_M = 14617;
  localparam int unsigned AW        = 13;  // holds 0..Q-1
  localparam int unsigned PW        = 25;  // holds (Q-1)^2
  localparam int unsigned MW        = 39;  // holds (Q-1)^2 * BARRETT_M

  logic          in_range_c;
  logic [AW-1:0] a1, b1;
  logic          ok1, v1;
  logic [PW-1:0] p2;
  logic          ok2, v2;

  logic [MW-1:0] bar_prod_c;
  logic [AW-1:0] bar_q_c;
  logic [PW-1:0] bar_r0_c, bar_r1_c, bar_r2_c;

  assign in_range_c = (in_a < W'(Q)) && (in_b < W'(Q));

  // S1: capture operands; out-of-range pairs are zeroed so the multiply stays bounded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a1  <= '0;
      b1  <= '0;
      ok1 <= 1'b0;
      v1  <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        ok1 <= in_range_c;
        a1  <= in_range_c ? AW'(in_a) : '0;
        b1  <= in_range_c ? AW'(in_b) : '0;
      end
    end
  end

  // S2: full product
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p2  <= '0;
      ok2 <= 1'b0;
      v2  <= 1'b0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        p2  <= PW'(a1) * PW'(b1);
        ok2 <= ok1;
      end
    end
  end

  // Barrett estimate undershoots the true quotient by at most 2, hence two correction steps
  always_comb begin
    bar_prod_c = MW'(p2) * MW'(BARRETT_M);
    bar_q_c    = AW'(bar_prod_c >> BARRETT_K);
    bar_r0_c   = p2 - (PW'(bar_q_c) * PW'(Q));
    bar_r1_c   = (bar_r0_c >= PW'(Q)) ? (bar_r0_c - PW'(Q)) : bar_r0_c;
    bar_r2_c   = (bar_r1_c >= PW'(Q)) ? (bar_r1_c - PW'(Q)) : bar_r1_c;
  end

  // S3: result register; data holds its last value across bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      err       <= v2 & ~ok2;
      if (v2) begin
        out <= ok2 ? W'(bar_r2_c) : '0;
      end
    end
  end

endmodule

// File: tb/tb_mulmod4591.sv
// Directed checks for mulmod4591: latency, streaming, range errors, stalls, bubbles, reset.
module tb_mulmod4591;

  logic        clk;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] out;
  logic        out_valid;
  logic        err;

  int vectors;
  int miscompares;

  mulmod4591 dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .out       (out),
    .out_valid (out_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b1;
    drive(1'b1, 16'd7, 16'd9);
    tick();
    tick();
    vectors++;
    if (out !== 16'd0 || out_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held: out=%0d valid=%b err=%b, want 0/0/0", out, out_valid, err);
    end
    drive(1'b0, 16'd0, 16'd0);
    #3 reset = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (out !== 16'd0 || out_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: out=%0d valid=%b err=%b, want 0/0/0", out, out_valid, err);
    end
  endtask

  task automatic test_inverse();
    drive(1'b1, 16'd3, 16'd3061);
    tick();
    drive(1'b0, 16'd0, 16'd0);
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL inverse_early: valid=%b after 2 edges, want 0", out_valid);
    end
    tick();
    vectors++;
    if (out !== 16'd1 || out_valid !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL inverse: out=%0d valid=%b err=%b, want 1/1/0", out, out_valid, err);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL inverse_drop: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [4];
    logic [15:0] pb [4];
    logic [15:0] ex [4];
    pa = '{16'd4590, 16'd4590, 16'd0,    16'd4590};
    pb = '{16'd4590, 16'd2,    16'd1234, 16'd1};
    ex = '{16'd1,    16'd4589, 16'd0,    16'd4590};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, pa[k], pb[k]);
      else drive(1'b0, 16'd0, 16'd0);
      tick();
      if (k >= 2) begin
        vectors++;
        if (out !== ex[k-2] || out_valid !== 1'b1 || err !== 1'b0) begin
          miscompares++;
          $display("FAIL back_to_back[%0d]: out=%0d valid=%b err=%b, want %0d/1/0",
                   k-2, out, out_valid, err, ex[k-2]);
        end
      end
    end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic [15:0] ex [3];
    logic        ee [3];
    pa = '{16'd4591, 16'd5,      16'd2};
    pb = '{16'd5,    16'hFFFF,   16'd2};
    ex = '{16'd0,    16'd0,      16'd4};
    ee = '{1'b1,     1'b1,       1'b0};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, pa[k], pb[k]);
      else drive(1'b0, 16'd0, 16'd0);
      tick();
      if (k >= 2) begin
        vectors++;
        if (out !== ex[k-2] || out_valid !== 1'b1 || err !== ee[k-2]) begin
          miscompares++;
          $display("FAIL out_of_range[%0d]: out=%0d valid=%b err=%b, want %0d/1/%b",
                   k-2, out, out_valid, err, ex[k-2], ee[k-2]);
        end
      end
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_unqualified: valid=%b err=%b, want 0/0", out_valid, err);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 16'd10, 16'd20);     // 200
    tick();
    drive(1'b1, 16'd100, 16'd100);   // 10000 mod 4591 = 818
    tick();
    drive(1'b1, 16'd4590, 16'd3);    // -3 = 4588
    tick();
    vectors++;
    if (out !== 16'd200 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_first: out=%0d valid=%b, want 200/1", out, out_valid);
    end
    en = 1'b0;
    drive(1'b1, 16'd4000, 16'd4000);
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (out !== 16'd200 || out_valid !== 1'b1 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_frozen[%0d]: out=%0d valid=%b err=%b, want 200/1/0",
                 k, out, out_valid, err);
      end
    end
    en = 1'b1;
    drive(1'b0, 16'd0, 16'd0);
    tick();
    vectors++;
    if (out !== 16'd818 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_second: out=%0d valid=%b, want 818/1", out, out_valid);
    end
    tick();
    vectors++;
    if (out !== 16'd4588 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_third: out=%0d valid=%b, want 4588/1", out, out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_lost_input: valid=%b, want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_bubbles();
    logic        ev [6];
    logic [15:0] ex [6];
    ev = '{1'b0, 1'b0, 1'b1,     1'b0,     1'b1,    1'b0};
    ex = '{16'd0, 16'd0, 16'd1636, 16'd1636, 16'd365, 16'd365};
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       drive(1'b1, 16'd100, 16'd200);
        2:       drive(1'b1, 16'd4000, 16'd4000);
        default: drive(1'b0, 16'd0, 16'd0);
      endcase
      tick();
      if (k >= 2) begin
        vectors++;
        if (out_valid !== ev[k] || err !== 1'b0 || out !== ex[k]) begin
          miscompares++;
          $display("FAIL bubbles[%0d]: out=%0d valid=%b err=%b, want %0d/%b/0",
                   k, out, out_valid, err, ex[k], ev[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit seen;
    drive(1'b1, 16'd50, 16'd60);
    tick();
    drive(1'b1, 16'd70, 16'd80);
    tick();
    drive(1'b0, 16'd0, 16'd0);
    reset = 1'b0;
    #1;
    vectors++;
    if (out !== 16'd0 || out_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async: out=%0d valid=%b err=%b, want 0/0/0", out, out_valid, err);
    end
    tick();
    #3 reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid !== 1'b0 || out !== 16'd0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL midreset_flushed: discarded pair emerged, want valid=0 out=0");
    end
    drive(1'b1, 16'd3, 16'd3061);
    tick();
    drive(1'b0, 16'd0, 16'd0);
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_early: valid=%b, want 0", out_valid);
    end
    tick();
    vectors++;
    if (out !== 16'd1 || out_valid !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_after: out=%0d valid=%b err=%b, want 1/1/0", out, out_valid, err);
    end
    tick();
  endtask

  task automatic test_random();
    localparam int N = 2000;
    int unsigned ex [N];
    int unsigned a, b;
    for (int k = 0; k < N + 2; k++) begin
      if (k < N) begin
        if (k < 4) begin
          a = (k[0]) ? 4590 : 0;
          b = (k[1]) ? 4590 : 1;
        end else begin
          a = $urandom_range(4590, 0);
          b = $urandom_range(4590, 0);
        end
        ex[k] = (a * b) % 4591;
        drive(1'b1, 16'(a), 16'(b));
      end else begin
        drive(1'b0, 16'd0, 16'd0);
      end
      tick();
      if (k >= 2) begin
        vectors++;
        if (out !== 16'(ex[k-2]) || out_valid !== 1'b1 || err !== 1'b0) begin
          miscompares++;
          $display("FAIL random[%0d]: out=%0d valid=%b err=%b, want %0d/1/0",
                   k-2, out, out_valid, err, ex[k-2]);
        end
      end
    end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    en          = 1'b0;
    drive(1'b0, 16'd0, 16'd0);
    test_reset();
    test_inverse();
    test_back_to_back();
    test_out_of_range();
    test_stall();
    test_bubbles();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
